// File: rtl/dog_plane_gen.sv
// Difference-of-Gaussians plane generator: streams adjacent blurred-scale BRAM pairs
// and writes fuzzier - sharper for every pixel of every plane.
module dog_plane_gen #(
   parameter int unsigned DIMENSION    = 64,
   parameter int unsigned PIX_WIDTH    = 8,
   parameter int unsigned NUM_SCALES   = 3,
   parameter int unsigned READ_LATENCY = 2,
   localparam int unsigned N  = DIMENSION * DIMENSION,
   localparam int unsigned P  = NUM_SCALES - 1,
   localparam int unsigned AW = $clog2(N),
   localparam int unsigned SW = (P > 1) ? $clog2(P) : 1
) (
   input  logic                        clk,
   input  logic                        rst_in,
   input  logic                        start,
   input  logic                        bram_ready,
   input  logic [PIX_WIDTH-1:0]        sharper_pix,
   input  logic [PIX_WIDTH-1:0]        fuzzier_pix,
   output logic [AW-1:0]               rd_addr,
   output logic [SW-1:0]               scale_sel,
   output logic [AW-1:0]               wr_addr,
   output logic [SW-1:0]               wr_plane,
   output logic signed [PIX_WIDTH:0]   data_out,
   output logic                        wea,
   output logic                        busy,
   output logic                        done,
   output logic [1:0]                  state_num
);

   localparam int unsigned DW = $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic                   w_issue;
   logic                   w_last_addr;
   logic                   w_last_plane;
   logic [PIX_WIDTH:0]     w_diff;
   logic [AW-1:0]          r_rd_addr;
   logic [SW-1:0]          r_scale_sel;
   logic [DW-1:0]          r_drain_cnt;
   logic                   r_vld       [READ_LATENCY];
   logic [AW-1:0]          r_tag_addr  [READ_LATENCY];
   logic [SW-1:0]          r_tag_plane [READ_LATENCY];
   logic                   r_wea;
   logic [AW-1:0]          r_wr_addr;
   logic [SW-1:0]          r_wr_plane;
   logic [PIX_WIDTH:0]     r_data_out;
   logic                   r_busy;
   logic                   r_done;

   always_ff @(posedge clk) begin : state_reg
      if (rst_in) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin : next_state
      w_next_state = r_state;
      w_issue      = 1'b0;
      w_last_addr  = (r_rd_addr == AW'(N - 1));
      w_last_plane = (r_scale_sel == SW'(P - 1));
      w_diff       = {1'b0, fuzzier_pix} - {1'b0, sharper_pix};
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_READ;
         S_READ: begin
            w_issue = bram_ready;
            if (bram_ready && w_last_addr && w_last_plane) w_next_state = S_DRAIN;
         end
         S_DRAIN: if (r_drain_cnt == DW'(READ_LATENCY)) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Read address / scale walk; planes chain back-to-back with no bubble.
   always_ff @(posedge clk) begin : read_walk
      if (rst_in) begin
         r_rd_addr   <= '0;
         r_scale_sel <= '0;
         r_drain_cnt <= '0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_rd_addr   <= '0;
            r_scale_sel <= '0;
         end else if (w_issue) begin
            if (w_last_addr) begin
               r_rd_addr <= '0;
               if (!w_last_plane) r_scale_sel <= r_scale_sel + SW'(1);
            end else begin
               r_rd_addr <= r_rd_addr + AW'(1);
            end
         end
         r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DW'(1) : '0;
      end
   end

   // Tag pipeline matches the BRAM latency; it shifts even while issue is stalled.
   always_ff @(posedge clk) begin : tag_pipe
      if (rst_in) begin
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            r_vld[i]       <= 1'b0;
            r_tag_addr[i]  <= '0;
            r_tag_plane[i] <= '0;
         end
      end else begin
         r_vld[0]       <= w_issue;
         r_tag_addr[0]  <= r_rd_addr;
         r_tag_plane[0] <= r_scale_sel;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            r_vld[i]       <= r_vld[i-1];
            r_tag_addr[i]  <= r_tag_addr[i-1];
            r_tag_plane[i] <= r_tag_plane[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin : write_port
      if (rst_in) begin
         r_wea      <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_plane <= '0;
         r_data_out <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_wea <= r_vld[READ_LATENCY-1];
         if (r_vld[READ_LATENCY-1]) begin
            r_wr_addr  <= r_tag_addr[READ_LATENCY-1];
            r_wr_plane <= r_tag_plane[READ_LATENCY-1];
            r_data_out <= w_diff;
         end
         r_busy <= (w_next_state == S_READ) || (w_next_state == S_DRAIN);
         r_done <= (w_next_state == S_DONE);
      end
   end

   assign rd_addr   = r_rd_addr;
   assign scale_sel = r_scale_sel;
   assign wr_addr   = r_wr_addr;
   assign wr_plane  = r_wr_plane;
   assign data_out  = $signed(r_data_out);
   assign wea       = r_wea;
   assign busy      = r_busy;
   assign done      = r_done;
   assign state_num = r_state;

endmodule
